fifo_to_video_ctrl: RTL and testbench



---
 rtl/video_ddr_pkg.sv | 28 ++
 rtl/fifo_word_unpacker.sv | 78 +++++++
 rtl/fifo_to_video_ctrl.sv | 115 +++++++++++
 tb/tb_fifo_to_video_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_ddr_pkg.sv
// Shared constants and helpers for the video/DDR read path.
// FIFO_UNDERFLOW_FLAG_EN selects the red underflow fill colour instead of black.
package video_ddr_pkg;

   localparam int PIXEL_W = 24;
   localparam int LANE_W  = 32;
   localparam logic [7:0] ALPHA = 8'hff;

   localparam logic [PIXEL_W-1:0] FILL_RED   = 24'hff0000;
   localparam logic [PIXEL_W-1:0] FILL_BLACK = 24'h000000;

`ifdef FIFO_UNDERFLOW_FLAG_EN
   localparam logic [PIXEL_W-1:0] UNDERFLOW_FILL = FILL_RED;
`else
   localparam logic [PIXEL_W-1:0] UNDERFLOW_FILL = FILL_BLACK;
`endif

   typedef struct packed {
      logic vs;
      logic hs;
      logic de;
   } timing_t;

   function automatic int lanes_per_word(input int width);
      return width / LANE_W;
   endfunction

endpackage

// File: rtl/fifo_word_unpacker.sv
// Splits each FIFO word into 32-bit {alpha, RGB} lanes, one pixel per active cycle,
// popping the FIFO on lane 0 and substituting the fill colour when the FIFO runs dry.
module fifo_word_unpacker
   import video_ddr_pkg::*;
#(
   parameter int W = 128
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               frame_start_i,
   input  logic               de_i,
   input  logic [W-1:0]       fifo_data_i,
   input  logic               fifo_empty_i,
   output logic               rd_en_o,
   output logic               underflow_o,
   output logic [PIXEL_W-1:0] pixel_o
);

   localparam int N     = lanes_per_word(W);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N - 1);

   logic [CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
   logic [W-1:0]       word_q, word_d;
   logic               fill_q, fill_d;
   logic [PIXEL_W-1:0] pixel_q, pixel_d;
   logic               lane0;

   assign lane0       = (lane_cnt_q == '0);
   assign rd_en_o     = rst_n_i & de_i & lane0 & ~fifo_empty_i;
   assign underflow_o = de_i & lane0 & fifo_empty_i;
   assign pixel_o     = pixel_q;

   // fill_q keeps the remaining lanes of a missing word on the fill colour
   always_comb begin
      lane_cnt_d = lane_cnt_q;
      word_d     = word_q;
      fill_d     = fill_q;
      pixel_d    = '0;
      if (de_i) begin
         if (lane0) begin
            if (!fifo_empty_i) begin
               pixel_d = fifo_data_i[W-LANE_W +: PIXEL_W];
               word_d  = fifo_data_i << LANE_W;
               fill_d  = 1'b0;
            end else begin
               pixel_d = UNDERFLOW_FILL;
               word_d  = '0;
               fill_d  = 1'b1;
            end
         end else begin
            pixel_d = fill_q ? UNDERFLOW_FILL : word_q[W-LANE_W +: PIXEL_W];
            word_d  = word_q << LANE_W;
         end
         lane_cnt_d = (lane_cnt_q == LAST_LANE) ? '0 : lane_cnt_q + 1'b1;
      end
      if (frame_start_i) begin
         lane_cnt_d = '0;
         word_d     = '0;
         fill_d     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lane_cnt_q <= '0;
         word_q     <= '0;
         fill_q     <= 1'b0;
         pixel_q    <= '0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         word_q     <= word_d;
         fill_q     <= fill_d;
         pixel_q    <= pixel_d;
      end
   end

endmodule

// File: rtl/fifo_to_video_ctrl.sv
// Read-data FIFO to display timing bridge with per-line burst requests.
// FIFO_UNDERFLOW_FLAG_EN enables the sticky underflow flag and red fill.
module fifo_to_video_ctrl
   import video_ddr_pkg::*;
#(
   parameter int AXI4_DATA_WIDTH = 128,
   parameter int V_ACTIVE        = 1080,
   parameter int PREFETCH_LINES  = 2
) (
   input  logic                       video_clk,
   input  logic                       video_rst_n,
   input  logic                       video_vs_in,
   input  logic                       video_hs_in,
   input  logic                       video_de_in,
   input  logic [AXI4_DATA_WIDTH-1:0] fifo_data_in,
   input  logic                       fifo_empty,
   output logic                       fifo_rd_en,
   output logic                       video_vs_out,
   output logic                       video_hs_out,
   output logic                       video_de_out,
   output logic [PIXEL_W-1:0]         video_data_out,
   output logic                       AXI_FULL_BURST_VALID,
   input  logic                       AXI_FULL_BURST_READY,
   output logic                       underflow_flag
);

   localparam int LINE_W = $clog2(V_ACTIVE + 1);
   localparam logic [LINE_W-1:0] LINES_MAX = LINE_W'(V_ACTIVE);
   localparam logic [LINE_W-1:0] PREFETCH  = LINE_W'(PREFETCH_LINES);
   localparam logic [3:0] PREFETCH_REQ     = 4'(PREFETCH_LINES);

   timing_t           timing_q;
   logic              frame_start, line_end, handshake, underflow;
   logic [LINE_W-1:0] lines_req_q, lines_req_d;
   logic [2:0]        req_pending_q, req_pending_d;
   logic [3:0]        req_add, req_sum;
   logic              armed_q, armed_d, valid_q;

   assign frame_start = video_vs_in & ~timing_q.vs;
   assign line_end    = ~video_de_in & timing_q.de;
   assign handshake   = valid_q & AXI_FULL_BURST_READY;

   fifo_word_unpacker #(
      .W(AXI4_DATA_WIDTH)
   ) u_unpacker (
      .clk_i        (video_clk),
      .rst_n_i      (video_rst_n),
      .frame_start_i(frame_start),
      .de_i         (video_de_in),
      .fifo_data_i  (fifo_data_in),
      .fifo_empty_i (fifo_empty),
      .rd_en_o      (fifo_rd_en),
      .underflow_o  (underflow),
      .pixel_o      (video_data_out)
   );

   // Line ends only count once a frame start has been seen since reset
   always_comb begin
      lines_req_d = lines_req_q;
      armed_d     = armed_q;
      req_add     = '0;
      if (frame_start) begin
         lines_req_d = PREFETCH;
         armed_d     = 1'b1;
         req_add     = PREFETCH_REQ;
      end else if (line_end && armed_q && (lines_req_q < LINES_MAX)) begin
         lines_req_d = lines_req_q + 1'b1;
         req_add     = 4'd1;
      end
      req_sum       = {1'b0, req_pending_q} + req_add - {3'b000, handshake};
      req_pending_d = (req_sum > 4'd7) ? 3'd7 : req_sum[2:0];
   end

   always_ff @(posedge video_clk or negedge video_rst_n) begin
      if (!video_rst_n) begin
         timing_q      <= '0;
         lines_req_q   <= '0;
         req_pending_q <= '0;
         armed_q       <= 1'b0;
         valid_q       <= 1'b0;
      end else begin
         timing_q      <= {video_vs_in, video_hs_in, video_de_in};
         lines_req_q   <= lines_req_d;
         req_pending_q <= req_pending_d;
         armed_q       <= armed_d;
         valid_q       <= (req_pending_d != 3'd0);
      end
   end

   assign video_vs_out         = timing_q.vs;
   assign video_hs_out         = timing_q.hs;
   assign video_de_out         = timing_q.de;
   assign AXI_FULL_BURST_VALID = valid_q;

`ifdef FIFO_UNDERFLOW_FLAG_EN
   logic underflow_q;

   always_ff @(posedge video_clk or negedge video_rst_n) begin
      if (!video_rst_n)
         underflow_q <= 1'b0;
      else if (frame_start)
         underflow_q <= 1'b0;
      else if (underflow)
         underflow_q <= 1'b1;
   end

   assign underflow_flag = underflow_q;
`else
   logic unused_underflow;

   assign unused_underflow = underflow;
   assign underflow_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_to_video_ctrl.sv
// Self-checking bench for fifo_to_video_ctrl: pixel scoreboard, timing delay,
// burst-request counting, underflow fill and mid-line reset.
module tb_fifo_to_video_ctrl;

   localparam int W     = 128;
   localparam int DEPTH = 64;

`ifdef FIFO_UNDERFLOW_FLAG_EN
   localparam logic [23:0] EXP_FILL = 24'hff0000;
   localparam logic        EXP_FLAG = 1'b1;
`else
   localparam logic [23:0] EXP_FILL = 24'h000000;
   localparam logic        EXP_FLAG = 1'b0;
`endif

   typedef struct {
      logic        vs;
      logic        hs;
      logic        de;
      logic        expRd;
      logic [23:0] expData;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic vsIn = 1'b0, hsIn = 1'b0, deIn = 1'b0;
   logic readyA = 1'b0, readyB = 1'b0, starve = 1'b0;

   logic [W-1:0] fifoMem [DEPTH];
   int           wrPtr = 0;
   int           rdPtr = 0;
   logic [W-1:0] fifoData;
   logic         fifoEmpty;

   logic        rdEnA, vsOutA, hsOutA, deOutA, validA, flagA;
   logic [23:0] dataA;
   logic        rdEnB, vsOutB, hsOutB, deOutB, validB, flagB;
   logic [23:0] dataB;

   int total = 0;
   int bad = 0;
   int hsA = 0;
   int hsB = 0;
   int laneM = 0;
   int curWord = 0;
   bit fillM = 1'b0;
   logic prevVs = 1'b0;
   logic lastRdEn = 1'b0;
   bit holdB = 1'b0;
   bit noValidA = 1'b0;
   logic [23:0] expQ [$];
   vec_t vecs [12];

   assign fifoEmpty = (wrPtr == rdPtr) || starve;
   assign fifoData  = fifoMem[rdPtr % DEPTH];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rdEnA) rdPtr <= rdPtr + 1;
   end

   fifo_to_video_ctrl #(
      .AXI4_DATA_WIDTH(W), .V_ACTIVE(4), .PREFETCH_LINES(2)
   ) dutA (
      .video_clk(clk), .video_rst_n(rst_n),
      .video_vs_in(vsIn), .video_hs_in(hsIn), .video_de_in(deIn),
      .fifo_data_in(fifoData), .fifo_empty(fifoEmpty), .fifo_rd_en(rdEnA),
      .video_vs_out(vsOutA), .video_hs_out(hsOutA), .video_de_out(deOutA),
      .video_data_out(dataA), .AXI_FULL_BURST_VALID(validA),
      .AXI_FULL_BURST_READY(readyA), .underflow_flag(flagA)
   );

   fifo_to_video_ctrl #(
      .AXI4_DATA_WIDTH(W), .V_ACTIVE(8), .PREFETCH_LINES(2)
   ) dutB (
      .video_clk(clk), .video_rst_n(rst_n),
      .video_vs_in(vsIn), .video_hs_in(hsIn), .video_de_in(deIn),
      .fifo_data_in(fifoData), .fifo_empty(fifoEmpty), .fifo_rd_en(rdEnB),
      .video_vs_out(vsOutB), .video_hs_out(hsOutB), .video_de_out(deOutB),
      .video_data_out(dataB), .AXI_FULL_BURST_VALID(validB),
      .AXI_FULL_BURST_READY(readyB), .underflow_flag(flagB)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Word w carries pixels 4w+1 .. 4w+4, first pixel in the top lane
   task automatic loadWords(input int count);
      logic [W-1:0] w;
      for (int i = 0; i < count; i++) begin
         w = '0;
         for (int l = 0; l < 4; l++) w = {w[W-33:0], 8'hff, 24'(4 * wrPtr + l + 1)};
         fifoMem[wrPtr % DEPTH] = w;
         wrPtr++;
      end
   endtask

   task automatic applyStimulus(input logic vs, input logic hs, input logic de);
      logic expRd;
      vsIn = vs; hsIn = hs; deIn = de;
      @(negedge clk);
      if (vs && !prevVs) laneM = 0;
      expRd = de && (laneM == 0) && !fifoEmpty;
      checkOutput("rd_en_a", rdEnA, expRd);
      checkOutput("rd_en_b", rdEnB, expRd);
      lastRdEn = rdEnA;
      if (validA && readyA) hsA++;
      if (validB && readyB) hsB++;
      if (holdB) checkOutput("valid_b_held", validB, 1);
      if (noValidA) checkOutput("valid_a_quiet", validA, 0);
      if (de) begin
         if (laneM == 0) begin
            if (!fifoEmpty) begin
               curWord = rdPtr;
               fillM = 1'b0;
            end else begin
               fillM = 1'b1;
            end
         end
         expQ.push_back(fillM ? EXP_FILL : 24'(4 * curWord + laneM + 1));
         laneM = (laneM + 1) % 4;
      end
      @(posedge clk);
      #1;
      prevVs = vs;
      checkOutput("vs_out", vsOutA, vs);
      checkOutput("hs_out", hsOutA, hs);
      checkOutput("de_out", deOutA, de);
      checkOutput("de_out_b", deOutB, de);
      if (deOutA) begin
         if (expQ.size() == 0) begin
            checkOutput("pixel_unexpected", 1, 0);
         end else begin
            logic [23:0] e;
            e = expQ.pop_front();
            checkOutput("pixel_a", dataA, e);
            checkOutput("pixel_b", dataB, e);
         end
      end else begin
         checkOutput("blank_data", dataA, 0);
      end
   endtask

   task automatic runVs();
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      repeat (3) applyStimulus(0, 0, 0);
   endtask

   task automatic runLine(input bit raiseReadyA, input bit starveLane0);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      for (int p = 0; p < 8; p++) begin
         starve = starveLane0 && (p == 0);
         applyStimulus(0, 0, 1);
      end
      starve = 1'b0;
      if (raiseReadyA) readyA = 1'b1;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      vecs[0]  = '{0, 1, 0, 0, 24'h0};
      vecs[1]  = '{0, 0, 0, 0, 24'h0};
      for (int p = 0; p < 8; p++) vecs[2 + p] = '{0, 0, 1, (p % 4 == 0), 24'(p + 1)};
      vecs[10] = '{0, 0, 0, 0, 24'h0};
      vecs[11] = '{0, 0, 0, 0, 24'h0};
      loadWords(16);

      // Reset state, with de high and data available to show rd_en is gated
      deIn = 1'b1; readyA = 1'b1; readyB = 1'b1;
      #3 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rd_en", rdEnA, 0);
      checkOutput("reset_vs", vsOutA, 0);
      checkOutput("reset_hs", hsOutA, 0);
      checkOutput("reset_de", deOutA, 0);
      checkOutput("reset_data", dataA, 0);
      checkOutput("reset_valid", validA, 0);
      checkOutput("reset_flag", flagA, 0);
      checkOutput("reset_valid_b", validB, 0);
      deIn = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Frame 1: READY high on A; READY low on B for three lines
      readyB = 1'b0;
      runVs();
      holdB = 1'b1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].vs, vecs[i].hs, vecs[i].de);
         checkOutput("vec_rd_en", lastRdEn, vecs[i].expRd);
         checkOutput("vec_data", dataA, vecs[i].expData);
      end
      runLine(0, 0);
      runLine(0, 0);
      holdB = 1'b0;
      readyB = 1'b1;
      base = hsB;
      repeat (7) applyStimulus(0, 0, 0);
      checkOutput("burst_b_count", hsB - base, 5);
      checkOutput("burst_b_drained", validB, 0);
      runLine(0, 0);
      repeat (4) applyStimulus(0, 0, 0);
      checkOutput("frame1_requests", hsA, 4);
      checkOutput("frame1_idle_valid", validA, 0);

      // Frame 2: line-end/handshake coincidence, then underflow on line 2
      readyA = 1'b0;
      base = hsA;
      runVs();
      runLine(1, 0);
      checkOutput("coincide_valid", validA, 1);
      runLine(0, 1);
      checkOutput("underflow_flag", flagA, EXP_FLAG);
      checkOutput("underflow_flag_b", flagB, EXP_FLAG);
      runLine(0, 0);
      runLine(0, 0);
      repeat (4) applyStimulus(0, 0, 0);
      checkOutput("frame2_requests", hsA - base, 4);

      // Frame 3: flag clears at frame start, then reset in the middle of a line
      loadWords(8);
      readyA = 1'b0;
      runVs();
      checkOutput("flag_cleared", flagA, 0);
      checkOutput("valid_pending", validA, 1);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      repeat (3) applyStimulus(0, 0, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_rd_en", rdEnA, 0);
      checkOutput("midreset_de", deOutA, 0);
      checkOutput("midreset_data", dataA, 0);
      checkOutput("midreset_valid", validA, 0);
      checkOutput("midreset_flag", flagA, 0);
      vsIn = 1'b0; hsIn = 1'b0; deIn = 1'b0;
      expQ.delete();
      laneM = 0; fillM = 1'b0; prevVs = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      readyA = 1'b1;
      noValidA = 1'b1;
      applyStimulus(0, 0, 0);
      repeat (5) applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      runLine(0, 0);
      noValidA = 1'b0;
      applyStimulus(1, 0, 0);
      checkOutput("valid_after_vs", validA, 1);
      applyStimulus(1, 0, 0);
      repeat (3) applyStimulus(0, 0, 0);
      checkOutput("scoreboard_empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
